// File: rtl/pc_sequencer_pkg.sv
// Shared widths, vectors and encodings for the PC sequencer and its return-address stack.
package pc_sequencer_pkg;

    localparam int unsigned AW        = 8;
    localparam int unsigned RAS_DEPTH = 4;

    localparam logic [AW-1:0] RESET_VECTOR = 8'h00;
    localparam logic [AW-1:0] IRQ_VECTOR   = 8'hF0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_BR,
        SEL_RET,
        SEL_CALL,
        SEL_IRQ,
        SEL_INC
    } sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: write pointer plus saturating count; a push while full
// overwrites the oldest entry so later pops still return the newest entries.
module pc_ras
    import pc_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data_c,
    output logic          empty_c,
    output logic          overflow_c,
    output logic          underflow_c
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [AW-1:0]    mem_q [RAS_DEPTH];
    logic [AW-1:0]    mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;

    // Status and top-of-stack; the pointer wraps naturally because depth is a power of two
    always_comb begin
        ptr_dec     = ptr_q - PTR_W'(1);
        full        = (cnt_q == CNT_W'(RAS_DEPTH));
        empty_c     = (cnt_q == '0);
        top_data_c  = mem_q[ptr_dec];
        overflow_c  = push & full;
        underflow_c = pop & empty_c;
    end

    // Next-state for storage, pointer and count; a pop on an empty stack changes nothing
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty_c) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Stack registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority next-PC select, interrupt entry FSM and the PC register.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          call,
    input  logic [AW-1:0] call_target,
    input  logic          ret,
    input  logic          irq,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pcnext,
    output logic          irq_ack,
    output logic          in_isr,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    sel_e          sel;
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pc_inc;
    logic          irq_ack_q, irq_ack_d;
    logic          ras_overflow_q, ras_overflow_d;
    logic          ras_underflow_q, ras_underflow_d;

    logic          ras_push;
    logic          ras_pop;
    logic [AW-1:0] ras_push_data;
    logic [AW-1:0] ras_top_c;
    logic          ras_empty_c;
    logic          ras_ovf_c;
    logic          ras_udf_c;

    pc_ras u_ras (
        .clk         (clk),
        .rst         (rst),
        .push        (ras_push),
        .pop         (ras_pop),
        .push_data   (ras_push_data),
        .top_data_c  (ras_top_c),
        .empty_c     (ras_empty_c),
        .overflow_c  (ras_ovf_c),
        .underflow_c (ras_udf_c)
    );

    // Priority select: stall > branch > ret > call > irq entry (RUN only) > increment
    always_comb begin
        sel = SEL_INC;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end else if (ret) begin
            sel = SEL_RET;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (irq && (state_q == ST_RUN)) begin
            sel = SEL_IRQ;
        end
    end

    // Next PC, stack requests and FSM transition for the winning action only
    always_comb begin
        pc_inc        = pc_q + AW'(1);
        pc_d          = pc_q;
        state_d       = state_q;
        irq_ack_d     = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ras_push_data = pc_inc;
        unique case (sel)
            SEL_HOLD: pc_d = pc_q;
            SEL_BR:   pc_d = branch_target;
            SEL_RET: begin
                ras_pop = 1'b1;
                if (ras_empty_c) begin
                    pc_d = pc_inc;
                end else begin
                    pc_d    = ras_top_c;
                    state_d = ST_RUN;
                end
            end
            SEL_CALL: begin
                ras_push      = 1'b1;
                ras_push_data = pc_inc;
                pc_d          = call_target;
            end
            SEL_IRQ: begin
                // Push the interrupted PC itself so that instruction re-executes on return
                ras_push      = 1'b1;
                ras_push_data = pc_q;
                pc_d          = IRQ_VECTOR;
                state_d       = ST_ISR;
                irq_ack_d     = 1'b1;
            end
            default:  pc_d = pc_inc;
        endcase
    end

    // Sticky stack error flags
    always_comb begin
        ras_overflow_d  = ras_overflow_q | ras_ovf_c;
        ras_underflow_d = ras_underflow_q | ras_udf_c;
    end

    // PC, FSM state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= RESET_VECTOR;
            state_q         <= ST_RUN;
            irq_ack_q       <= 1'b0;
            ras_overflow_q  <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            state_q         <= state_d;
            irq_ack_q       <= irq_ack_d;
            ras_overflow_q  <= ras_overflow_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    assign pc            = pc_q;
    assign pcnext        = pc_d;
    assign irq_ack       = irq_ack_q;
    assign in_isr        = (state_q == ST_ISR);
    assign ras_overflow  = ras_overflow_q;
    assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       call;
    logic [7:0] call_target;
    logic       ret;
    logic       irq;
    logic [7:0] pc;
    logic [7:0] pcnext;
    logic       irq_ack;
    logic       in_isr;
    logic       ras_overflow;
    logic       ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .call_target   (call_target),
        .ret           (ret),
        .irq           (irq),
        .pc            (pc),
        .pcnext        (pcnext),
        .irq_ack       (irq_ack),
        .in_isr        (in_isr),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic       br;
        logic [7:0] bt;
        logic       call;
        logic [7:0] ct;
        logic       ret;
        logic       irq;
        logic [7:0] exp_pc;
        logic       exp_ack;
        logic       exp_isr;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic b, logic [7:0] bt, logic c, logic [7:0] ct,
                                logic r, logic i, logic [7:0] p, logic a, logic isr,
                                logic ovf, logic udf);
        vec_t v;
        v.stall = s;  v.br = b;   v.bt = bt;   v.call = c;  v.ct = ct;
        v.ret = r;    v.irq = i;  v.exp_pc = p; v.exp_ack = a;
        v.exp_isr = isr; v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] p, input logic a,
                           input logic isr, input logic ovf, input logic udf);
        chk({tag, " pc"}, pc, p);
        chk({tag, " irq_ack"}, 8'(irq_ack), 8'(a));
        chk({tag, " in_isr"}, 8'(in_isr), 8'(isr));
        chk({tag, " ras_overflow"}, 8'(ras_overflow), 8'(ovf));
        chk({tag, " ras_underflow"}, 8'(ras_underflow), 8'(udf));
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        call = 1'b0; call_target = 8'h00; ret = 1'b0; irq = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        //              s  br bt     c  ct     r  i  pc     ack isr ovf udf
        // free-running and wrap
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
        // single call / return
        vecs.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h40, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h41, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h42, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h11, 0, 0, 0, 0));
        // five nested calls overflow the 4-deep stack
        vecs.push_back(mk(0, 1, 8'h20, 0, 8'h00, 0, 0, 8'h20, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h30, 0, 0, 8'h30, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h40, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h50, 0, 0, 8'h50, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h60, 0, 0, 8'h60, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h70, 0, 0, 8'h70, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h61, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h51, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h41, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h31, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h32, 0, 0, 1, 1));
        // interrupt entry, no nesting, return to interrupted pc
        vecs.push_back(mk(0, 1, 8'h25, 0, 8'h00, 0, 0, 8'h25, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hF0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hF1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h25, 0, 0, 1, 1));
        // stall beats branch and irq; then branch beats irq; then irq enters
        vecs.push_back(mk(1, 1, 8'h80, 0, 8'h00, 0, 1, 8'h25, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 8'h80, 0, 8'h00, 0, 1, 8'h80, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hF0, 1, 1, 1, 1));
        // call inside the ISR leaves two stack entries
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h90, 0, 0, 8'h90, 0, 1, 1, 1));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset pcnext", pcnext, 8'h01);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            stall         = vecs[k].stall;
            branch_taken  = vecs[k].br;
            branch_target = vecs[k].bt;
            call          = vecs[k].call;
            call_target   = vecs[k].ct;
            ret           = vecs[k].ret;
            irq           = vecs[k].irq;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", k), vecs[k].exp_pc, vecs[k].exp_ack,
                    vecs[k].exp_isr, vecs[k].exp_ovf, vecs[k].exp_udf);
        end

        // asynchronous reset mid-ISR: visible before the next clock edge
        idle_inputs();
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;

        // stack contents were discarded: a return underflows and increments
        ret = 1'b1;
        #1;
        chk("ret_empty pcnext", pcnext, 8'h01);
        @(posedge clk);
        #1;
        chk_all("ret_after_rst", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);

        // irq is accepted again once back in RUN after reset
        ret = 1'b0;
        irq = 1'b1;
        #1;
        chk("irq pcnext", pcnext, 8'hF0);
        @(posedge clk);
        #1;
        chk_all("irq_after_rst", 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1);
        irq = 1'b0;
        @(posedge clk);
        #1;
        chk_all("isr_step", 8'hF1, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequencing controller for the 8-bit program counter register of the pipelined microprocessor.
- Each cycle it chooses the next PC from one of: hold (stall), branch redirect, return, call, interrupt vector, or sequential increment.
- Contains a small hardware return-address stack (RAS) and a two-state interrupt FSM.
- Sits between decode/execute control and the instruction-fetch stage; owns the PC register.

Parameters:
AW, 8, address width of PC and all targets
RAS_DEPTH, 4, return-address stack entries (power of 2)
RESET_VECTOR, 8'h00, PC value after reset
IRQ_VECTOR, 8'hF0, ISR entry address

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC and all state this cycle
branch_taken  input  1  redirect request from execute
branch_target  input  AW  redirect address
call  input  1  subroutine call: push return address, jump
call_target  input  AW  call destination
ret  input  1  pop RAS, jump to popped address
irq  input  1  level interrupt request
pc  output  AW  registered program counter
pcnext  output  AW  combinational value pc takes at next edge
irq_ack  output  1  registered 1-cycle pulse on ISR entry
in_isr  output  1  high while FSM is in ISR
ras_overflow  output  1  sticky: push while full
ras_underflow  output  1  sticky: pop while empty

Behaviour:
- One clock; reset is asynchronous and active-high on rst. On reset: pc=RESET_VECTOR, state=RUN, RAS count=0, irq_ack=0, in_isr=0, ras_overflow=0, ras_underflow=0. Reset mid-operation discards RAS contents and ISR state immediately.
- Per-cycle priority, highest first: stall > branch_taken > ret > call > irq entry > pc+1. Only the winning action updates any state.
- stall=1: pcnext=pc. No RAS, FSM or flag change. irq_ack=0.
- branch_taken: pcnext=branch_target.
- call: push (pc+1) mod 2^AW, then pcnext=call_target.
- ret, RAS non-empty: pop, then pcnext=popped value. If state=ISR, return to RUN.
- ret, RAS empty: pcnext=pc+1, set ras_underflow. FSM unchanged.
- Push when count=RAS_DEPTH: the oldest entry is overwritten (circular), count stays at RAS_DEPTH, set ras_overflow.
- Sequential: pcnext=pc+1, wrapping 8'hFF -> 8'h00.
- FSM states:
  - RUN: irq=1 and no higher-priority action -> push pc (interrupted instruction re-executes on return), pcnext=IRQ_VECTOR, go to ISR, irq_ack=1 on the next cycle only.
  - ISR: irq is ignored (no nesting). A successful ret returns to RUN. Calls inside the ISR use the same RAS.
- Latency: pc reflects pcnext exactly one edge later. irq_ack is asserted in the same cycle pc first equals IRQ_VECTOR.
- RAS is implemented as a pointer plus count. Pop after a circular overwrite returns the newest entries in LIFO order.

Decomposition:
- Shared package: AW, RESET_VECTOR, IRQ_VECTOR, FSM state encoding (RUN=1'b0, ISR=1'b1), next-PC select enum (SEL_HOLD, SEL_BR, SEL_RET, SEL_CALL, SEL_IRQ, SEL_INC).
- One sub-module: pc_ras (push/pop/full/empty, circular overwrite, overflow/underflow strobes). The top level holds the priority mux, FSM and PC register.

Test Plan:
- Reset then 3 free-running cycles -> pc 00,01,02. Force pc to FF, run one cycle -> pc=00.
- At pc=10: call to 40, then 2 cycles, then ret -> pc 40,41,42 then 11. Stack empty afterwards.
- Five nested calls at pc=20,30,40,50,60 (DEPTH=4) -> ras_overflow=1. Four rets return 61,51,41,31. Fifth ret -> ras_underflow=1, pc increments.
- irq asserted at pc=25 -> next pc=F0, irq_ack=1 for one cycle, in_isr=1. Hold irq high, no re-entry. ret -> pc=25, in_isr=0.
- Same cycle: stall=1, branch_taken=1 (target 80), irq=1 -> pc holds, nothing changes. Next cycle with stall=0 -> pc=80, irq deferred one cycle, then pc=F0.
- Assert rst asynchronously mid-ISR with 2 RAS entries -> pc=00 and in_isr=0 before the next edge. A following ret -> ras_underflow=1.
